// File: rtl/pong_match_ctrl.sv
// Match sequencer for the two-bar LED-matrix pong game.
// It gates the ball engine, requests serve reloads, keeps both scores and
// produces the decimal-packed score value for the 7-segment driver.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | power-up, waiting for the first serve press
// SERVE      | ball parked on the serving bar, counting down dly ticks
// RALLY      | ball engine free-running, watching for misses and pause
// PAUSED     | rally frozen until the next pause press
// POINT      | frozen ball shown after a miss, counting down dly ticks
// GAME_OVER  | a player reached WIN_SCORE, waiting for serve to restart
module pong_match_ctrl #(
    parameter logic [3:0] WIN_SCORE   = 4'd7,
    parameter logic [7:0] SERVE_DELAY = 8'd8,
    parameter logic [7:0] POINT_HOLD  = 8'd16
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        tick,
    input  logic        serve_p,
    input  logic        pause_p,
    input  logic        miss_up,
    input  logic        miss_down,
    output logic        ball_run,
    output logic        ball_load,
    output logic        serve_side,
    output logic [3:0]  score_p1,
    output logic [3:0]  score_p2,
    output logic [13:0] seg_value,
    output logic        game_over,
    output logic        winner,
    output logic [2:0]  state_o
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SERVE     = 3'd1,
        ST_RALLY     = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_POINT     = 3'd4,
        ST_GAME_OVER = 3'd5
    } state_t;

    // A zero delay parameter would never expire, so it is treated as one tick.
    localparam logic [7:0] SERVE_LOAD = (SERVE_DELAY == 8'd0) ? 8'd1 : SERVE_DELAY;
    localparam logic [7:0] POINT_LOAD = (POINT_HOLD  == 8'd0) ? 8'd1 : POINT_HOLD;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] dly;
    logic [7:0] dly_nxt;
    logic [3:0] score_p1_nxt;
    logic [3:0] score_p2_nxt;
    logic       serve_side_nxt;
    logic       winner_nxt;
    logic       dly_expire;
    logic [3:0] score_p1_inc;
    logic [3:0] score_p2_inc;

    // Saturating score increments; the game normally ends before saturation matters.
    assign score_p1_inc = (score_p1 >= WIN_SCORE) ? WIN_SCORE : score_p1 + 4'd1;
    assign score_p2_inc = (score_p2 >= WIN_SCORE) ? WIN_SCORE : score_p2 + 4'd1;

    // Terminal count of the tick down-counter; <= guards against a stray zero.
    assign dly_expire = tick && (dly <= 8'd1);

    // Next-state and next-datapath decode.
    always_comb begin
        state_nxt      = state;
        dly_nxt        = dly;
        score_p1_nxt   = score_p1;
        score_p2_nxt   = score_p2;
        serve_side_nxt = serve_side;
        winner_nxt     = winner;

        case (state)
            ST_IDLE, ST_GAME_OVER: begin
                if (serve_p) begin
                    state_nxt      = ST_SERVE;
                    dly_nxt        = SERVE_LOAD;
                    score_p1_nxt   = 4'd0;
                    score_p2_nxt   = 4'd0;
                    serve_side_nxt = 1'b0;
                    winner_nxt     = 1'b0;
                end
            end
            ST_SERVE: begin
                if (dly_expire) begin
                    state_nxt = ST_RALLY;
                end else if (tick) begin
                    dly_nxt = dly - 8'd1;
                end
            end
            ST_RALLY: begin
                if (miss_up) begin
                    state_nxt      = ST_POINT;
                    dly_nxt        = POINT_LOAD;
                    score_p1_nxt   = score_p1_inc;
                    serve_side_nxt = 1'b1;
                end else if (miss_down) begin
                    state_nxt      = ST_POINT;
                    dly_nxt        = POINT_LOAD;
                    score_p2_nxt   = score_p2_inc;
                    serve_side_nxt = 1'b0;
                end else if (pause_p) begin
                    state_nxt = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (pause_p) begin
                    state_nxt = ST_RALLY;
                end
            end
            ST_POINT: begin
                if (dly_expire) begin
                    if (score_p1 == WIN_SCORE) begin
                        state_nxt  = ST_GAME_OVER;
                        winner_nxt = 1'b0;
                    end else if (score_p2 == WIN_SCORE) begin
                        state_nxt  = ST_GAME_OVER;
                        winner_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_SERVE;
                        dly_nxt   = SERVE_LOAD;
                    end
                end else if (tick) begin
                    dly_nxt = dly - 8'd1;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, counter, scores and registered output decode.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state      <= ST_IDLE;
            dly        <= 8'd0;
            score_p1   <= 4'd0;
            score_p2   <= 4'd0;
            serve_side <= 1'b0;
            winner     <= 1'b0;
            ball_run   <= 1'b0;
            ball_load  <= 1'b0;
            game_over  <= 1'b0;
        end else begin
            state      <= state_nxt;
            dly        <= dly_nxt;
            score_p1   <= score_p1_nxt;
            score_p2   <= score_p2_nxt;
            serve_side <= serve_side_nxt;
            winner     <= winner_nxt;
            ball_run   <= (state_nxt == ST_RALLY);
            ball_load  <= (state_nxt == ST_SERVE) && (state != ST_SERVE);
            game_over  <= (state_nxt == ST_GAME_OVER);
        end
    end

    assign state_o   = state;
    assign seg_value = ({10'd0, score_p2} * 14'd100) + {10'd0, score_p1};

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed scenarios plus a long
// randomized run checked against a game-level reference model.
module tb_pong_match_ctrl;

    localparam int W  = 7;
    localparam int SD = 8;
    localparam int PH = 16;

    logic        CLK;
    logic        RSTn;
    logic        tick, serve_p, pause_p, miss_up, miss_down;
    logic        ball_run, ball_load, serve_side, game_over, winner;
    logic [3:0]  score_p1, score_p2;
    logic [13:0] seg_value;
    logic [2:0]  state_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: game phase (0 idle,1 serve,2 rally,3 paused,4 point,5 over)
    int m_phase, m_left, m_p1, m_p2, m_side, m_win, m_load;

    pong_match_ctrl #(
        .WIN_SCORE  (4'd7),
        .SERVE_DELAY(8'd8),
        .POINT_HOLD (8'd16)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .tick      (tick),
        .serve_p   (serve_p),
        .pause_p   (pause_p),
        .miss_up   (miss_up),
        .miss_down (miss_down),
        .ball_run  (ball_run),
        .ball_load (ball_load),
        .serve_side(serve_side),
        .score_p1  (score_p1),
        .score_p2  (score_p2),
        .seg_value (seg_value),
        .game_over (game_over),
        .winner    (winner),
        .state_o   (state_o)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_phase = 0; m_left = 0; m_p1 = 0; m_p2 = 0;
        m_side = 0; m_win = 0; m_load = 0;
    endtask

    task automatic model_new_game();
        m_p1 = 0; m_p2 = 0; m_side = 0; m_win = 0;
        m_phase = 1; m_left = (SD < 1) ? 1 : SD; m_load = 1;
    endtask

    task automatic model_update(input bit t, input bit s, input bit p, input bit mu, input bit md);
        m_load = 0;
        if (m_phase == 0 || m_phase == 5) begin
            if (s) model_new_game();
        end else if (m_phase == 1) begin
            if (t) begin
                if (m_left == 1) m_phase = 2;
                else m_left = m_left - 1;
            end
        end else if (m_phase == 2) begin
            if (mu) begin
                m_p1 = (m_p1 + 1 > W) ? W : m_p1 + 1;
                m_side = 1; m_phase = 4; m_left = (PH < 1) ? 1 : PH;
            end else if (md) begin
                m_p2 = (m_p2 + 1 > W) ? W : m_p2 + 1;
                m_side = 0; m_phase = 4; m_left = (PH < 1) ? 1 : PH;
            end else if (p) begin
                m_phase = 3;
            end
        end else if (m_phase == 3) begin
            if (p) m_phase = 2;
        end else if (m_phase == 4) begin
            if (t) begin
                if (m_left == 1) begin
                    if (m_p1 == W) begin m_phase = 5; m_win = 0; end
                    else if (m_p2 == W) begin m_phase = 5; m_win = 1; end
                    else begin m_phase = 1; m_left = (SD < 1) ? 1 : SD; m_load = 1; end
                end else begin
                    m_left = m_left - 1;
                end
            end
        end
    endtask

    task automatic step(input bit t, input bit s, input bit p, input bit mu, input bit md);
        tick = t; serve_p = s; pause_p = p; miss_up = mu; miss_down = md;
        @(posedge CLK);
        model_update(t, s, p, mu, md);
        #1;
        tick = 0; serve_p = 0; pause_p = 0; miss_up = 0; miss_down = 0;
    endtask

    task automatic do_reset();
        RSTn = 0;
        tick = 0; serve_p = 0; pause_p = 0; miss_up = 0; miss_down = 0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();
        RSTn = 1;
    endtask

    task automatic to_rally();
        step(0, 1, 0, 0, 0);
        for (int i = 0; i < SD; i++) begin
            step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_reset();
        RSTn = 0;
        tick = 0; serve_p = 0; pause_p = 0; miss_up = 0; miss_down = 0;
        #12;
        n_tests++;
        if ({state_o, ball_run, ball_load, serve_side, score_p1, score_p2, seg_value, game_over, winner}
            !== 31'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: state=%0d run=%0d load=%0d side=%0d p1=%0d p2=%0d seg=%0d over=%0d win=%0d, required all 0",
                     state_o, ball_run, ball_load, serve_side, score_p1, score_p2, seg_value, game_over, winner);
        end
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0, 0);
            n_tests++;
            if (ball_load !== 1'b0 || state_o !== 3'd0 || ball_run !== 1'b0 || seg_value !== 14'd0) begin
                n_fail++;
                $display("FAIL reset_idle: load=%0d state=%0d run=%0d seg=%0d, required 0 0 0 0",
                         ball_load, state_o, ball_run, seg_value);
            end
        end
    endtask

    task automatic test_serve();
        do_reset();
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (ball_load !== 1'b1 || state_o !== 3'd1) begin
            n_fail++;
            $display("FAIL serve_load: load=%0d state=%0d, required 1 1", ball_load, state_o);
        end
        step(0, 0, 0, 0, 0);
        n_tests++;
        if (ball_load !== 1'b0) begin
            n_fail++;
            $display("FAIL serve_load_width: load=%0d, required 0", ball_load);
        end
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 0, 0, 0);
            n_tests++;
            if (i < 8) begin
                if (ball_run !== 1'b0 || state_o !== 3'd1) begin
                    n_fail++;
                    $display("FAIL serve_hold tick %0d: run=%0d state=%0d, required 0 1", i, ball_run, state_o);
                end
            end else begin
                if (ball_run !== 1'b1 || state_o !== 3'd2) begin
                    n_fail++;
                    $display("FAIL serve_release: run=%0d state=%0d, required 1 2", ball_run, state_o);
                end
            end
            step(0, 0, 0, 0, 0);
        end
    endtask

    task automatic test_point();
        do_reset();
        to_rally();
        step(0, 0, 0, 1, 0);
        n_tests++;
        if (state_o !== 3'd4 || score_p1 !== 4'd1 || seg_value !== 14'd1 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL point_enter: state=%0d p1=%0d seg=%0d run=%0d, required 4 1 1 0",
                     state_o, score_p1, seg_value, ball_run);
        end
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 0, 0, 0);
            n_tests++;
            if (i < 16) begin
                if (state_o !== 3'd4 || ball_run !== 1'b0) begin
                    n_fail++;
                    $display("FAIL point_hold tick %0d: state=%0d run=%0d, required 4 0", i, state_o, ball_run);
                end
            end else begin
                if (state_o !== 3'd1 || ball_load !== 1'b1 || serve_side !== 1'b1) begin
                    n_fail++;
                    $display("FAIL point_reserve: state=%0d load=%0d side=%0d, required 1 1 1",
                             state_o, ball_load, serve_side);
                end
            end
        end
    endtask

    task automatic test_dual_miss();
        do_reset();
        to_rally();
        step(0, 0, 0, 1, 1);
        n_tests++;
        if (score_p1 !== 4'd1 || score_p2 !== 4'd0 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL dual_miss: p1=%0d p2=%0d state=%0d, required 1 0 4", score_p1, score_p2, state_o);
        end
        step(0, 0, 0, 0, 1);
        n_tests++;
        if (score_p2 !== 4'd0 || score_p1 !== 4'd1) begin
            n_fail++;
            $display("FAIL miss_in_point: p1=%0d p2=%0d, required 1 0", score_p1, score_p2);
        end
        do_reset();
        to_rally();
        step(0, 0, 1, 0, 1);
        n_tests++;
        if (state_o !== 3'd4 || score_p2 !== 4'd1 || serve_side !== 1'b0) begin
            n_fail++;
            $display("FAIL miss_over_pause: state=%0d p2=%0d side=%0d, required 4 1 0", state_o, score_p2, serve_side);
        end
    endtask

    task automatic test_pause();
        do_reset();
        to_rally();
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (state_o !== 3'd3 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL pause_enter: state=%0d run=%0d, required 3 0", state_o, ball_run);
        end
        step(1, 0, 0, 0, 1);
        n_tests++;
        if (score_p2 !== 4'd0 || state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL pause_miss: p2=%0d state=%0d, required 0 3", score_p2, state_o);
        end
        step(0, 0, 1, 0, 0);
        n_tests++;
        if (state_o !== 3'd2 || ball_run !== 1'b1) begin
            n_fail++;
            $display("FAIL pause_resume: state=%0d run=%0d, required 2 1", state_o, ball_run);
        end
    endtask

    task automatic test_game_over();
        do_reset();
        step(0, 1, 0, 0, 0);
        for (int k = 0; k < 7; k++) begin
            for (int i = 0; i < SD; i++) step(1, 0, 0, 0, 0);
            step(0, 0, 0, 0, 1);
            for (int i = 0; i < PH; i++) step(1, 0, 0, 0, 0);
        end
        n_tests++;
        if (seg_value !== 14'd700 || game_over !== 1'b1 || winner !== 1'b1 || state_o !== 3'd5 || ball_run !== 1'b0) begin
            n_fail++;
            $display("FAIL game_over: seg=%0d over=%0d win=%0d state=%0d run=%0d, required 700 1 1 5 0",
                     seg_value, game_over, winner, state_o, ball_run);
        end
        step(1, 0, 0, 1, 0);
        n_tests++;
        if (seg_value !== 14'd700 || state_o !== 3'd5) begin
            n_fail++;
            $display("FAIL game_over_frozen: seg=%0d state=%0d, required 700 5", seg_value, state_o);
        end
        step(0, 1, 0, 0, 0);
        n_tests++;
        if (seg_value !== 14'd0 || state_o !== 3'd1 || ball_load !== 1'b1 || game_over !== 1'b0 || serve_side !== 1'b0) begin
            n_fail++;
            $display("FAIL game_restart: seg=%0d state=%0d load=%0d over=%0d side=%0d, required 0 1 1 0 0",
                     seg_value, state_o, ball_load, game_over, serve_side);
        end
    endtask

    task automatic test_reset_midrally();
        do_reset();
        to_rally();
        step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        #2;
        RSTn = 0;
        #1;
        n_tests++;
        if (state_o !== 3'd0 || ball_run !== 1'b0 || score_p1 !== 4'd0 || serve_side !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: state=%0d run=%0d p1=%0d side=%0d, required 0 0 0 0",
                     state_o, ball_run, score_p1, serve_side);
        end
        do_reset();
    endtask

    task automatic test_random();
        bit t, s, p, mu, md;
        do_reset();
        for (int c = 0; c < 6000; c++) begin
            t  = ($urandom_range(0, 2) == 0);
            s  = ($urandom_range(0, 19) == 0);
            p  = ($urandom_range(0, 39) == 0);
            mu = ($urandom_range(0, 14) == 0);
            md = ($urandom_range(0, 14) == 0);
            step(t, s, p, mu, md);
            n_tests++;
            if (state_o !== 3'(m_phase) || ball_run !== (m_phase == 2) || ball_load !== 1'(m_load) ||
                serve_side !== 1'(m_side) || score_p1 !== 4'(m_p1) || score_p2 !== 4'(m_p2) ||
                seg_value !== 14'(m_p2 * 100 + m_p1) || game_over !== (m_phase == 5) ||
                (m_phase == 5 && winner !== 1'(m_win))) begin
                n_fail++;
                $display("FAIL random cycle %0d: state=%0d run=%0d load=%0d side=%0d p1=%0d p2=%0d seg=%0d over=%0d win=%0d, required state=%0d load=%0d side=%0d p1=%0d p2=%0d win=%0d",
                         c, state_o, ball_run, ball_load, serve_side, score_p1, score_p2, seg_value,
                         game_over, winner, m_phase, m_load, m_side, m_p1, m_p2, m_win);
            end
        end
    endtask

    initial begin
        RSTn = 0;
        tick = 0; serve_p = 0; pause_p = 0; miss_up = 0; miss_down = 0;
        model_reset();
        test_reset();
        test_serve();
        test_point();
        test_dual_miss();
        test_pause();
        test_game_over();
        test_reset_midrally();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
